pad_stream_tx: RTL and testbench

Bus-side transmitter for a PE's fmap or weight pad loader: streams `total_len` words from a local source buffer into the PE pad FIFO over the pad's `bus_ready` / `pe_ready` handshake. It issues the pad's one-cycle `load_start` pulse before the data and supports bursted delivery with programmable idle gaps, so a pad can be partially filled, drained and refilled. One instance sits between the global buffer read port and each PE pad input (`pe_fmap_in` / `pe_weight_in`).

---
 rtl/pad_stream_tx.sv | 165 ++++++++++++++++
 tb/tb_pad_stream_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pad_stream_tx.sv
// Streams total_len words from a source buffer into a PE pad FIFO, preceded by a
// load_start pulse, with optional fixed-length idle gaps between bursts.
module pad_stream_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  total_len,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic [LEN_WIDTH-1:0]  gap_cycles,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  load_start,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic                  bus_ready,
  input  logic                  pe_ready,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state
);

  // Handshake: a word transfers on a rising edge where bus_ready && pe_ready;
  // while bus_ready is high and pe_ready is low, bus_data and bus_ready hold.

  typedef enum logic [2:0] {S_IDLE, S_START, S_STREAM, S_GAP, S_DONE} state_t;

  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic [LEN_WIDTH-1:0]    rd_left_q, rd_left_d;
  logic [LEN_WIDTH-1:0]    send_left_q, send_left_d;
  logic [LEN_WIDTH-1:0]    burst_q, burst_d;
  logic [LEN_WIDTH-1:0]    gap_q, gap_d;
  logic [LEN_WIDTH-1:0]    burst_cnt_q, burst_cnt_d;
  logic [LEN_WIDTH-1:0]    gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0]   fifo_q [2];
  logic [DATA_WIDTH-1:0]   fifo_d [2];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;
  logic                    inflight_q, inflight_d;

  logic       pop;
  logic       active;
  logic       issue;
  logic [2:0] occ;

  always_comb begin
    state_d     = state_q;
    raddr_d     = raddr_q;
    rd_left_d   = rd_left_q;
    send_left_d = send_left_q;
    burst_d     = burst_q;
    gap_d       = gap_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    bus_ready  = (state_q == S_STREAM) && (count_q != 2'd0);
    bus_data   = fifo_q[rd_ptr_q];
    pop        = bus_ready && pe_ready;
    active     = (state_q == S_START) || (state_q == S_STREAM) || (state_q == S_GAP);
    // Occupancy projected past this cycle's pop, counting the read still in flight.
    occ        = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue      = active && (rd_left_q != '0) && (occ < 3'd2);
    mem_ren    = issue;
    mem_raddr  = raddr_q;
    inflight_d = issue;
    load_start = (state_q == S_START);
    done       = (state_q == S_DONE);
    busy       = (state_q != S_IDLE);
    dbg_state  = state_q;

    if (issue) begin
      raddr_d   = raddr_q + ADDR_ONE;
      rd_left_d = rd_left_q - LEN_ONE;
    end
    if (inflight_q) begin
      fifo_d[wr_ptr_q] = mem_rdata;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          raddr_d     = base_addr;
          rd_left_d   = total_len;
          send_left_d = total_len;
          burst_d     = burst_len;
          gap_d       = gap_cycles;
          burst_cnt_d = '0;
          state_d     = S_START;
        end
      end
      S_START: state_d = (send_left_q == '0) ? S_DONE : S_STREAM;
      S_STREAM: begin
        if (pop) begin
          send_left_d = send_left_q - LEN_ONE;
          burst_cnt_d = burst_cnt_q + LEN_ONE;
          if (send_left_q == LEN_ONE) begin
            state_d = S_DONE;
          end else if ((burst_q != '0) && (gap_q != '0) && (burst_cnt_d == burst_q)) begin
            gap_cnt_d = gap_q;
            state_d   = S_GAP;
          end
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q - LEN_ONE;
        if (gap_cnt_q == LEN_ONE) begin
          burst_cnt_d = '0;
          state_d     = S_STREAM;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      raddr_q     <= '0;
      rd_left_q   <= '0;
      send_left_q <= '0;
      burst_q     <= '0;
      gap_q       <= '0;
      burst_cnt_q <= '0;
      gap_cnt_q   <= '0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      raddr_q     <= raddr_d;
      rd_left_q   <= rd_left_d;
      send_left_q <= send_left_d;
      burst_q     <= burst_d;
      gap_q       <= gap_d;
      burst_cnt_q <= burst_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      fifo_q[0]   <= fifo_d[0];
      fifo_q[1]   <= fifo_d[1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
    end
  end

endmodule

// File: tb/tb_pad_stream_tx.sv
// Directed bench for pad_stream_tx: source memory model, driver tasks, a
// scoreboard monitor on accepted words, and timing checks per scenario.
module tb_pad_stream_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [7:0]  total_len = '0;
  logic [7:0]  burst_len = '0;
  logic [7:0]  gap_cycles = '0;
  logic        mem_ren;
  logic [9:0]  mem_raddr;
  logic [15:0] mem_rdata = '0;
  logic        load_start;
  logic [15:0] bus_data;
  logic        bus_ready;
  logic        pe_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  pad_stream_tx dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .total_len(total_len), .burst_len(burst_len), .gap_cycles(gap_cycles),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .load_start(load_start), .bus_data(bus_data), .bus_ready(bus_ready),
    .pe_ready(pe_ready), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / cycle counter / source memory (mem[i] = i+1)
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [15:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = 16'(i + 1);
  always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_raddr];

  int n_checks = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];
  int          acc_q[$];
  int          ls_q[$];
  int          done_q[$];
  int          ren_q[$];
  int          br_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      if (load_start) ls_q.push_back(cyc);
      if (done) done_q.push_back(cyc);
      if (mem_ren) ren_q.push_back(int'(mem_raddr));
      if (bus_ready) br_cnt++;
      if (prev_stall) begin
        chk("stall_hold_ready", {31'd0, bus_ready}, 32'd1);
        chk("stall_hold_data", {16'd0, bus_data}, {16'd0, prev_data});
      end
      if (bus_ready && pe_ready) begin
        acc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_word: got %0d expected none", bus_data);
        end else begin
          chk("bus_data", {16'd0, bus_data}, {16'd0, exp_q.pop_front()});
        end
      end
      prev_stall = bus_ready && !pe_ready;
      prev_data  = bus_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_logs();
    acc_q.delete(); ls_q.delete(); done_q.delete(); ren_q.delete();
    br_cnt = 0;
  endtask

  task automatic start_xfer(input int base, input int len, input int burst, input int gap);
    clear_logs();
    for (int i = 0; i < len; i++) exp_q.push_back(16'(((base + i) % 1024) + 1));
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'(base); total_len = 8'(len);
    burst_len = 8'(burst); gap_cycles = 8'(gap);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_q.size() == 0 && n < budget) begin
      @(posedge clk); n++;
    end
    if (done_q.size() == 0) begin
      n_checks++; n_err++;
      $display("FAIL done_timeout: got none expected done within %0d cycles", budget);
    end
    repeat (2) @(posedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_acc(input int k, input int budget);
    int n = 0;
    while (acc_q.size() < k && n < budget) begin
      @(posedge clk); n++;
    end
    if (acc_q.size() < k) begin
      n_checks++; n_err++;
      $display("FAIL acc_timeout: got %0d words expected %0d", acc_q.size(), k);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_mem_ren"}, {31'd0, mem_ren}, 0);
    chk({tag, "_mem_raddr"}, {22'd0, mem_raddr}, 0);
    chk({tag, "_load_start"}, {31'd0, load_start}, 0);
    chk({tag, "_bus_data"}, {16'd0, bus_data}, 0);
    chk({tag, "_bus_ready"}, {31'd0, bus_ready}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
  endtask

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // single burst
    start_xfer(0, 12, 0, 0);
    wait_done(100);
    chk("t1_ls_count", ls_q.size(), 1);
    chk("t1_acc_count", acc_q.size(), 12);
    if (ls_q.size() == 1 && acc_q.size() == 12 && done_q.size() == 1) begin
      chk("t1_first_word", acc_q[0], ls_q[0] + 2);
      chk("t1_last_word", acc_q[11], ls_q[0] + 13);
      chk("t1_done", done_q[0], ls_q[0] + 14);
    end

    // bursted with 20-cycle gap
    start_xfer(0, 12, 6, 20);
    wait_done(200);
    chk("t2_acc_count", acc_q.size(), 12);
    if (ls_q.size() == 1 && acc_q.size() == 12 && done_q.size() == 1) begin
      chk("t2_first_word", acc_q[0], ls_q[0] + 2);
      chk("t2_burst1", acc_q[5] - acc_q[0], 5);
      chk("t2_gap", acc_q[6] - acc_q[5], 21);
      chk("t2_burst2", acc_q[11] - acc_q[6], 5);
      chk("t2_done", done_q[0], acc_q[11] + 1);
    end

    // backpressure: 5 stalled cycles after word 3, then toggling
    start_xfer(0, 12, 0, 0);
    wait_acc(3, 100);
    #1 pe_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 pe_ready = 1'b1;
    for (int n = 0; n < 200 && done_q.size() == 0; n++) begin
      @(posedge clk); #1 pe_ready = ~pe_ready;
    end
    pe_ready = 1'b1;
    wait_done(50);
    chk("t3_acc_count", acc_q.size(), 12);
    if (acc_q.size() == 12) chk("t3_resume", acc_q[3] - acc_q[2], 6);

    // zero length
    start_xfer(0, 0, 0, 0);
    wait_done(20);
    chk("t4_ls_count", ls_q.size(), 1);
    if (ls_q.size() == 1 && done_q.size() == 1) chk("t4_done", done_q[0], ls_q[0] + 1);
    chk("t4_no_ren", ren_q.size(), 0);
    chk("t4_no_ready", br_cnt, 0);

    // address wrap
    start_xfer(1022, 4, 0, 0);
    wait_done(50);
    chk("t5_ren_count", ren_q.size(), 4);
    if (ren_q.size() == 4) begin
      chk("t5_raddr0", ren_q[0], 1022);
      chk("t5_raddr1", ren_q[1], 1023);
      chk("t5_raddr2", ren_q[2], 0);
      chk("t5_raddr3", ren_q[3], 1);
    end
    chk("t5_acc_count", acc_q.size(), 4);

    // reset mid-stream, then fresh stream with a start pulsed while busy
    start_xfer(0, 12, 0, 0);
    wait_acc(5, 100);
    #1 rst = 1'b0;
    exp_q.delete();
    #1 check_outputs_zero("midreset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    start_xfer(0, 12, 0, 0);
    wait_acc(3, 100);
    #1 start = 1'b1; base_addr = 10'd500; total_len = 8'd3;
    @(posedge clk); #1 start = 1'b0;
    wait_done(100);
    chk("t6_acc_count", acc_q.size(), 12);
    chk("t6_ls_count", ls_q.size(), 1);
    chk("t6_done_count", done_q.size(), 1);
    chk("t6_ren_count", ren_q.size(), 12);
    if (ren_q.size() == 12) chk("t6_last_raddr", ren_q[11], 11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
